// File: rtl/ram_backing.sv
// ram_backing: word-addressed backing memory that answers cache-to-RAM requests
// after a fixed latency. The whole array is swept to zero after every reset.
//
// Ports:
//   clk       - clock, all state updates on posedge
//   rst_n     - synchronous active-low reset
//   data      - write data of the request triple
//   address   - word address, only the low ADDR_BITS are used
//   mode      - 0 = read, 1 = write
//   out       - read data (or echoed write data) of the last completed request
//   response  - 1 while clearing or servicing a request, 0 when idle and out valid
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_INIT | zeroing mem[clr_ptr] each cycle, inputs ignored
// S_IDLE | watching the input triple for a change against the latched one
// S_BUSY | counting down the latency, completing the request at cnt == 0

module ram_backing #(
  parameter int SIZE      = 4096,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        mode,
  output logic [31:0] out,
  output logic        response
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SIZE - 1);
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_BUSY
  } state_t;

  logic [31:0] mem [SIZE];

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_ptr_q, clr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           out_q, out_d;
  logic                  response_q, response_d;
  logic [ADDR_BITS-1:0]  la_q, la_d;
  logic [31:0]           ld_q, ld_d;
  logic                  lm_q, lm_d;
  logic                  first_q, first_d;

  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_waddr;
  logic [31:0]           mem_wdata;

  logic [ADDR_BITS-1:0]  addr_idx;
  logic                  req_new;

  // Upper address bits are deliberately ignored, including for change detection.
  logic                  unused_addr_hi;

  assign addr_idx       = address[ADDR_BITS-1:0];
  assign unused_addr_hi = ^address[31:ADDR_BITS];
  assign req_new        = first_q || (addr_idx != la_q) || (data != ld_q) || (mode != lm_q);

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    response_d = response_q;
    la_d       = la_q;
    ld_d       = ld_q;
    lm_d       = lm_q;
    first_d    = first_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = 32'h0;

    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = 32'h0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          response_d = 1'b0;
        end
      end
      S_IDLE: begin
        if (req_new) begin
          la_d       = addr_idx;
          ld_d       = data;
          lm_d       = mode;
          first_d    = 1'b0;
          cnt_d      = CNT_LOAD;
          response_d = 1'b1;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (lm_q) begin
            mem_we    = 1'b1;
            mem_waddr = la_q;
            mem_wdata = ld_q;
            out_d     = ld_q;
          end else begin
            out_d = mem[la_q];
          end
          response_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      clr_ptr_q  <= '0;
      cnt_q      <= '0;
      out_q      <= 32'h0;
      response_q <= 1'b1;
      la_q       <= '0;
      ld_q       <= 32'h0;
      lm_q       <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      response_q <= response_d;
      la_q       <= la_d;
      ld_q       <= ld_d;
      lm_q       <= lm_d;
      first_q    <= first_d;
    end
  end

  // Gating with rst_n drops a write that would otherwise commit on a reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign out      = out_q;
  assign response = response_q;

endmodule

// File: tb/tb_ram_backing.sv
module tb_ram_backing;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [31:0] address;
  logic        mode;
  logic [31:0] out;
  logic        response;

  logic        rst_n1;
  logic [31:0] data1;
  logic [31:0] address1;
  logic        mode1;
  logic [31:0] out1;
  logic        response1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_backing #(.SIZE(16), .ADDR_BITS(4), .LATENCY(LAT)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .address  (address),
    .mode     (mode),
    .out      (out),
    .response (response)
  );

  ram_backing #(.SIZE(16), .ADDR_BITS(4), .LATENCY(1)) u_dut_l1 (
    .clk      (clk),
    .rst_n    (rst_n1),
    .data     (data1),
    .address  (address1),
    .mode     (mode1),
    .out      (out1),
    .response (response1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive samples with response high, starting at the current one.
  task automatic count_high(output int n);
    n = 0;
    while (response && n < 40) begin
      n++;
      tick();
    end
  endtask

  // Present a request while idle, wait for acceptance, measure the busy window.
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic m,
                     input logic [31:0] exp, input string tag);
    int n;
    int busy;
    address = a;
    data    = d;
    mode    = m;
    n = 0;
    tick();
    while (!response && n < 8) begin
      n++;
      tick();
    end
    check({tag, "_accept"}, 32'(response), 32'd1);
    count_high(busy);
    check({tag, "_busy"}, 32'(busy), 32'(LAT));
    check({tag, "_out"}, out, exp);
  endtask

  initial begin
    int n;
    int highs;
    int lows;

    rst_n1   = 1'b0;
    data1    = 32'h0;
    address1 = 32'h0;
    mode1    = 1'b0;

    // 1: reset and initial sweep; the first idle cycle picks up the read of 5
    rst_n   = 1'b0;
    address = 32'd5;
    data    = 32'h0;
    mode    = 1'b0;
    tick();
    tick();
    check("rst_response", 32'(response), 32'd1);
    check("rst_out", out, 32'h0);
    rst_n = 1'b1;
    count_high(n);
    check("init_len", 32'(n), 32'd16);
    check("init_out", out, 32'h0);
    req(32'd5, 32'h0, 1'b0, 32'h0, "rd5");

    // 2: write then read
    req(32'd3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, "wr3");
    req(32'd3, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, "rd3");

    // 3: address wrap
    req(32'd2, 32'h11, 1'b1, 32'h11, "wr2");
    req(32'd18, 32'h11, 1'b0, 32'h11, "rd18");
    address = 32'd34;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (response) highs++;
    end
    check("wrap_no_req", 32'(highs), 32'd0);
    check("wrap_out_hold", out, 32'h11);

    // 4: held triple gives exactly one window
    req(32'd3, 32'h11, 1'b0, 32'hDEADBEEF, "held");
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (response) highs++;
    end
    check("held_no_repeat", 32'(highs), 32'd0);

    // 5: inputs change in the 2nd busy cycle
    address = 32'd3;
    data    = 32'h0;
    mode    = 1'b0;
    n = 0;
    tick();
    while (!response && n < 8) begin
      n++;
      tick();
    end
    check("chg_accept", 32'(response), 32'd1);
    tick();
    address = 32'd7;
    data    = 32'h77;
    mode    = 1'b1;
    count_high(n);
    check("chg_first_busy", 32'(n + 1), 32'(LAT));
    check("chg_first_out", out, 32'hDEADBEEF);
    lows = 0;
    while (!response && lows < 8) begin
      lows++;
      tick();
    end
    check("chg_gap", 32'(lows), 32'd1);
    count_high(n);
    check("chg_second_busy", 32'(n), 32'(LAT));
    check("chg_second_out", out, 32'h77);
    req(32'd7, 32'h77, 1'b0, 32'h77, "rd7");

    // 6: reset in the middle of a write
    address = 32'd9;
    data    = 32'h99;
    mode    = 1'b1;
    n = 0;
    tick();
    while (!response && n < 8) begin
      n++;
      tick();
    end
    check("rstb_accept", 32'(response), 32'd1);
    tick();
    rst_n   = 1'b0;
    address = 32'd9;
    data    = 32'h0;
    mode    = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstb_out", out, 32'h0);
    count_high(n);
    check("rstb_init_len", 32'(n), 32'd16);
    req(32'd9, 32'h0, 1'b0, 32'h0, "rstb_rd9");

    // LATENCY = 1 instance
    address1 = 32'd4;
    data1    = 32'hAB;
    mode1    = 1'b1;
    tick();
    rst_n1 = 1'b1;
    n = 0;
    while (response1 && n < 40) begin
      n++;
      tick();
    end
    check("l1_init_len", 32'(n), 32'd16);
    tick();
    check("l1_wr_busy", 32'(response1), 32'd1);
    tick();
    check("l1_wr_done", 32'(response1), 32'd0);
    check("l1_wr_out", out1, 32'hAB);
    mode1 = 1'b0;
    data1 = 32'h0;
    tick();
    check("l1_rd_busy", 32'(response1), 32'd1);
    tick();
    check("l1_rd_done", 32'(response1), 32'd0);
    check("l1_rd_out", out1, 32'hAB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
